wb_lfsr_master: RTL and testbench
=================================

// Module: wb_lfsr_master
// PURPOSE
//  Wishbone (pipelined) initiator that drives the wb_lfsr responder: a write programs the LFSR
//  (seed/control at address 0/1), reads fetch successive 1-bit LFSR outputs and pack them into a byte.
//  Sits between a simple valid/ready command port and the wb_lfsr slave port in the tt_um_lfsr top.
//  One outstanding Wishbone request at a time; CYC is held across all beats of a read burst.
// PARAMETERS
//  DATA_W   8   write data width and read-pack register width
//  ADDR_W   1   Wishbone address width
//  TIMEOUT  15  max cycles per beat (REQ+WAIT) before abort; counter width = clog2(TIMEOUT+1)
// PORTS
//  i_clk         in   1       clock
//  i_reset       in   1       asynchronous, active-high reset
//  i_cmd_valid   in   1       command request
//  o_cmd_ready   out  1       high only in IDLE; command accepted when valid & ready
//  i_cmd_we      in   1       1 = write (single beat), 0 = read burst
//  i_cmd_addr    in   ADDR_W  Wishbone address for every beat of the command
//  i_cmd_data    in   DATA_W  write data
//  i_cmd_len     in   3       read beats minus 1 (0 -> 1 beat, 7 -> 8 beats); ignored for writes
//  o_rsp_valid   out  1       response available; held until i_rsp_ready
//  i_rsp_ready   in   1       response consumed when valid & ready
//  o_rsp_data    out  DATA_W  packed read bits (0 for writes)
//  o_rsp_err     out  1       1 = beat timed out, command aborted
//  o_wb_cyc      out  1       Wishbone CYC
//  o_wb_stb      out  1       Wishbone STB
//  o_wb_we       out  1       Wishbone WE
//  o_wb_addr     out  ADDR_W  Wishbone address
//  o_wb_data     out  DATA_W  Wishbone write data
//  i_wb_stall    in   1       responder stall
//  i_wb_ack      in   1       responder acknowledge
//  i_wb_data     in   1       responder read data (LFSR output bit)
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0 except o_cmd_ready=1; state IDLE; counters/pack reg cleared.
//    Mid-transfer reset drops CYC/STB immediately; no response is produced for the killed command.
//  - States: IDLE -> REQ -> WAIT -> (REQ | RSP) -> IDLE; ABORT path WAIT/REQ -> RSP with err.
//  - IDLE: on cmd accept latch we/addr/data/len, clear pack reg and beat count; next cycle CYC=STB=1 (REQ).
//  - REQ: STB, WE, ADDR, DATA held stable while i_wb_stall=1; request issued in cycle STB & !stall;
//    next cycle STB=0, CYC=1, state WAIT. Latency cmd accept -> STB high = 1 cycle.
//  - WAIT: on i_wb_ack: read -> pack = {pack[DATA_W-2:0], i_wb_data}; if beats done -> RSP (CYC=0
//    same edge), else -> REQ next cycle (CYC stays 1). Write -> RSP, data 0.
//  - ACK seen while in REQ (same cycle as issue) is accepted for that beat: go directly to next REQ/RSP.
//  - ACK while CYC=0 or in IDLE/RSP is ignored.
//  - Timeout: per-beat counter reset on entering REQ, increments each REQ/WAIT cycle; when it reaches
//    TIMEOUT without ack -> drop CYC/STB, RSP with o_rsp_err=1, o_rsp_data = bits packed so far.
//  - RSP: o_rsp_valid=1, data/err stable until i_rsp_ready; then IDLE (cmd_ready=1 next cycle).
//  - Burst of N beats: first bit lands in pack[N-1], last in pack[0]; upper bits 0.
//  - Back-to-back commands: min 1 idle cycle (IDLE) between responses and next CYC.
// TESTING
//  1. Write addr 0 data 8'hA5, no stall, ack 1 cycle after STB -> one STB cycle WE=1 data A5; rsp data 0 err 0.
//  2. Read len=7, responder returns bits 1,0,1,1,0,0,1,0 -> 8 STB beats, CYC continuous, rsp_data 8'hB2.
//  3. Read len=2 with stall=1 for 3 cycles on beat 2 -> STB/ADDR held 4 cycles, rsp_data 3'b(b0 b1 b2).
//  4. No ack ever (TIMEOUT=15) -> CYC drops after 15 cycles, rsp_err=1, rsp_data 0.
//  5. Hold i_rsp_ready=0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0, no new CYC.
//  6. Assert i_reset during beat 3 of len=7 read -> CYC/STB 0 same cycle, no rsp, cmd_ready=1 after.

Source files
------------

// File: rtl/wb_lfsr_master.sv
// ----------------------------------------------------------------------------
// wb_lfsr_master
//
// Pipelined Wishbone initiator for the wb_lfsr responder. A command on the
// valid/ready port becomes either a single write beat (programs seed/control)
// or a read burst of 1..8 beats. Each read beat returns one LFSR bit, which is
// shifted into a pack register. The response is then offered on the
// valid/ready response port. Only one Wishbone request is outstanding at a
// time, and CYC stays high across every beat of a burst.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake (ready only while idle)
//   i_cmd_we                1 = single write beat, 0 = read burst
//   i_cmd_addr              Wishbone address used for every beat
//   i_cmd_data              write data
//   i_cmd_len               read beats minus one
//   o_rsp_valid/i_rsp_ready response handshake, held until consumed
//   o_rsp_data              packed read bits (0 for writes)
//   o_rsp_err               beat timed out, command aborted
//   o_wb_*                  Wishbone initiator outputs (CYC/STB/WE/ADR/DAT)
//   i_wb_stall/ack/data     Wishbone responder inputs (data is one LFSR bit)
// ----------------------------------------------------------------------------
module wb_lfsr_master #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [2:0]        i_cmd_len,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RSP
    } state_t;

    state_t state, state_nxt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        len_q;
    logic [2:0]        beat_q;
    logic [DATA_W-1:0] pack_q;
    logic              err_q;
    logic [CNT_W-1:0]  tmo_q;

    logic busy;
    logic accept;
    logic issue;
    logic beat_ack;
    logic last_beat;
    logic timed_out;

    assign busy   = (state == S_REQ) || (state == S_WAIT);
    assign accept = (state == S_IDLE) && i_cmd_valid;
    assign issue  = (state == S_REQ) && !i_wb_stall;

    // An ack is only meaningful for a request actually on the bus. That is
    // either the one being issued this cycle or the one we are waiting on.
    // Acks while stalled, idle or responding are ignored.
    assign beat_ack  = i_wb_ack && (issue || (state == S_WAIT));
    assign last_beat = we_q || (beat_q == len_q);

    // The per-beat budget covers REQ and WAIT cycles together. The current
    // cycle is the last one allowed when the counter shows TIMEOUT-1. An ack
    // arriving in that cycle still wins.
    assign timed_out = busy && !beat_ack && (tmo_q == CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge values. Blocking assignments here would make the result
    // depend on statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case. Every path through
    // the block then assigns it, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_cmd_valid) state_nxt = S_REQ;
            end
            S_REQ, S_WAIT: begin
                if (beat_ack) begin
                    state_nxt = last_beat ? S_RSP : S_REQ;
                end else if (timed_out) begin
                    state_nxt = S_RSP;
                end else if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, beat/timeout counters and read pack register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            pack_q <= '0;
            err_q  <= 1'b0;
            tmo_q  <= '0;
        end else if (accept) begin
            we_q   <= i_cmd_we;
            addr_q <= i_cmd_addr;
            data_q <= i_cmd_data;
            len_q  <= i_cmd_len;
            beat_q <= '0;
            pack_q <= '0;
            err_q  <= 1'b0;
            tmo_q  <= '0;
        end else if (busy) begin
            if (beat_ack) begin
                // The first bit ends up in pack[N-1] and the last in pack[0].
                if (!we_q) pack_q <= {pack_q[DATA_W-2:0], i_wb_data};
                beat_q <= beat_q + 3'd1;
                tmo_q  <= '0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_cmd_ready = (state == S_IDLE);
    assign o_rsp_valid = (state == S_RSP);
    assign o_rsp_data  = o_rsp_valid ? pack_q : '0;
    assign o_rsp_err   = o_rsp_valid && err_q;

    assign o_wb_cyc  = busy;
    assign o_wb_stb  = (state == S_REQ);
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = data_q;

endmodule

// File: tb/tb_wb_lfsr_master.sv
// ----------------------------------------------------------------------------
// tb_wb_lfsr_master
//
// Testbench for wb_lfsr_master. It provides a behavioural Wishbone responder
// with configurable ack latency, stall and ack-limit settings. Each command
// pushes its expected response into a scoreboard queue. A response monitor
// pops and compares an entry whenever a response handshake occurs. Inputs are
// driven 2 time units after the rising edge, and outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_wb_lfsr_master;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic       i_cmd_we;
    logic [0:0] i_cmd_addr;
    logic [7:0] i_cmd_data;
    logic [2:0] i_cmd_len;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_data;
    logic       o_rsp_err;
    logic       o_wb_cyc;
    logic       o_wb_stb;
    logic       o_wb_we;
    logic [0:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       i_wb_stall;
    logic       i_wb_ack;
    logic       i_wb_data;

    wb_lfsr_master #(
        .DATA_W (8),
        .ADDR_W (1),
        .TIMEOUT(15)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_we   (i_cmd_we),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_data (i_cmd_data),
        .i_cmd_len  (i_cmd_len),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    exp_t sb_q[$];
    logic bits_q[$];

    // Responder configuration, set by the main sequence between commands.
    int ack_lat    = 1;    // 0: ack in the issue cycle, 1: ack one cycle later
    int ack_limit  = 99;   // only beats with index below this are acked
    int stall_beat = -1;   // beat index that gets stalled
    int stall_left = 0;    // remaining stall cycles for that beat

    // Responder state and bus statistics.
    int         beat_idx  = 0;
    bit         ack_due   = 0;
    bit         prev_cyc  = 0;
    int         cyc_cnt   = 0;
    int         cyc_rise  = 0;
    int         stb_cnt   = 0;
    int         rsp_cnt   = 0;
    logic       last_we   = 1'b0;
    logic [0:0] last_addr = '0;
    logic [7:0] last_data = '0;
    bit         hold_pending = 0;
    logic       hold_we   = 1'b0;
    logic [0:0] hold_addr = '0;
    logic [7:0] hold_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic next_bit();
        if (bits_q.size() != 0) return bits_q.pop_front();
        return 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Wishbone responder and bus monitor, evaluated on the falling edge
    // ------------------------------------------------------------------
    initial begin
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_data  = 1'b0;
        forever begin
            @(negedge i_clk);
            i_wb_ack = 1'b0;
            if (ack_due) begin
                ack_due   = 0;
                i_wb_ack  = 1'b1;
                i_wb_data = next_bit();
            end
            if (o_wb_cyc) cyc_cnt++;
            if (o_wb_cyc && !prev_cyc) cyc_rise++;
            prev_cyc = o_wb_cyc;

            // Everything presented in a stalled cycle must still be there.
            if (hold_pending) begin
                hold_pending = 0;
                check("hold_stb",  o_wb_stb,  1'b1);
                check("hold_we",   o_wb_we,   hold_we);
                check("hold_addr", o_wb_addr, hold_addr);
                check("hold_data", o_wb_data, hold_data);
            end

            i_wb_stall = 1'b0;
            if (o_wb_stb) begin
                stb_cnt++;
                if (beat_idx == stall_beat && stall_left > 0) begin
                    i_wb_stall   = 1'b1;
                    stall_left--;
                    hold_pending = 1;
                    hold_we      = o_wb_we;
                    hold_addr    = o_wb_addr;
                    hold_data    = o_wb_data;
                end else begin
                    last_we   = o_wb_we;
                    last_addr = o_wb_addr;
                    last_data = o_wb_data;
                    if (beat_idx < ack_limit) begin
                        if (ack_lat == 0) begin
                            i_wb_ack  = 1'b1;
                            i_wb_data = next_bit();
                        end else begin
                            ack_due = 1;
                        end
                    end
                    beat_idx++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response monitor: the handshake completes on the next rising edge
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_rsp_valid && i_rsp_ready) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", o_rsp_data, e.data);
                    check("rsp_err",  o_rsp_err,  e.err);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic start_test(input int lat, input int s_beat, input int s_len, input int a_lim);
        ack_lat    = lat;
        stall_beat = s_beat;
        stall_left = s_len;
        ack_limit  = a_lim;
        beat_idx   = 0;
        ack_due    = 0;
        cyc_cnt    = 0;
        cyc_rise   = 0;
        stb_cnt    = 0;
        bits_q.delete();
    endtask

    // Pushes n bits in the order the responder returns them (v[n-1] first).
    task automatic set_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    task automatic send_cmd(input logic we, input logic [0:0] addr, input logic [7:0] data,
                            input logic [2:0] len, input logic [7:0] exp_data, input logic exp_err);
        exp_t e;
        int   n;
        e.err  = exp_err;
        e.data = exp_data;
        sb_q.push_back(e);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_data  = data;
        i_cmd_len   = len;
        n = 0;
        @(negedge i_clk);
        while (!o_cmd_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cmd_ready) check("cmd_accept", o_cmd_ready, 1'b1);
        @(posedge i_clk);
        #2;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_wait", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) @(posedge i_clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int rsp_before;

        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_data  = '0;
        i_cmd_len   = '0;
        i_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_cmd_ready", o_cmd_ready, 1'b1);
        check("rst_cyc",       o_wb_cyc,    1'b0);
        check("rst_stb",       o_wb_stb,    1'b0);
        check("rst_we",        o_wb_we,     1'b0);
        check("rst_wdata",     o_wb_data,   8'h00);
        check("rst_rsp_valid", o_rsp_valid, 1'b0);
        check("rst_rsp_data",  o_rsp_data,  8'h00);
        check("rst_rsp_err",   o_rsp_err,   1'b0);
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        @(posedge i_clk);
        #2;

        // 1: single write, ack one cycle after STB
        start_test(1, -1, 0, 99);
        send_cmd(1'b1, 1'b0, 8'hA5, 3'd0, 8'h00, 1'b0);
        wait_done();
        check("wr_stb_cnt", stb_cnt,   1);
        check("wr_cyc_cnt", cyc_cnt,   2);
        check("wr_we",      last_we,   1'b1);
        check("wr_addr",    last_addr, 1'b0);
        check("wr_data",    last_data, 8'hA5);

        // 2: 8-beat read, bits 1,0,1,1,0,0,1,0 -> B2
        start_test(1, -1, 0, 99);
        set_bits(8'b1011_0010, 8);
        send_cmd(1'b0, 1'b1, 8'h00, 3'd7, 8'hB2, 1'b0);
        wait_done();
        check("rd8_stb_cnt",  stb_cnt,   8);
        check("rd8_cyc_cnt",  cyc_cnt,   16);
        check("rd8_cyc_rise", cyc_rise,  1);
        check("rd8_we",       last_we,   1'b0);

        // 3: 3-beat read, second beat stalled 3 cycles, bits 1,1,0 -> 3'b110
        start_test(1, 1, 3, 99);
        set_bits(8'b0000_0110, 3);
        send_cmd(1'b0, 1'b1, 8'h00, 3'd2, 8'h06, 1'b0);
        wait_done();
        check("stall_stb_cnt",  stb_cnt,  6);
        check("stall_cyc_cnt",  cyc_cnt,  9);
        check("stall_cyc_rise", cyc_rise, 1);

        // 4: no ack at all -> CYC held exactly 15 cycles, error, data 0
        start_test(1, -1, 0, 0);
        send_cmd(1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1);
        wait_done();
        check("tmo_cyc_cnt", cyc_cnt, 15);

        // 4b: timeout on the third beat of a 4-beat read keeps bits so far
        start_test(1, -1, 0, 2);
        set_bits(8'b0000_0011, 2);
        send_cmd(1'b0, 1'b0, 8'h00, 3'd3, 8'h03, 1'b1);
        wait_done();
        check("tmo_mid_cyc_cnt", cyc_cnt, 19);

        // 5: response held while i_rsp_ready is low
        start_test(1, -1, 0, 99);
        set_bits(8'b0000_0001, 2);
        i_rsp_ready = 1'b0;
        send_cmd(1'b0, 1'b0, 8'h00, 3'd1, 8'h01, 1'b0);
        n = 0;
        while (!o_rsp_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("hold_rsp_valid", o_rsp_valid, 1'b1);
            check("hold_rsp_data",  o_rsp_data,  8'h01);
            check("hold_rsp_err",   o_rsp_err,   1'b0);
            check("hold_cmd_ready", o_cmd_ready, 1'b0);
            check("hold_cyc",       o_wb_cyc,    1'b0);
        end
        @(posedge i_clk);
        #2;
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("post_rsp_ready", o_cmd_ready, 1'b1);
        check("post_rsp_valid", o_rsp_valid, 1'b0);
        wait_done();

        // 6: reset asserted during beat 3 of an 8-beat read
        start_test(1, -1, 0, 99);
        set_bits(8'hFF, 8);
        send_cmd(1'b0, 1'b1, 8'h00, 3'd7, 8'hFF, 1'b0);
        n = 0;
        while (!(o_wb_stb && beat_idx == 2) && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("rst_mid_reached", o_wb_stb && beat_idx == 2, 1'b1);
        rsp_before = rsp_cnt;
        i_reset = 1'b1;
        #1;
        check("rst_mid_cyc",   o_wb_cyc,    1'b0);
        check("rst_mid_stb",   o_wb_stb,    1'b0);
        check("rst_mid_ready", o_cmd_ready, 1'b1);
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        sb_q.delete();
        repeat (10) @(negedge i_clk);
        check("rst_no_rsp",      rsp_cnt,     rsp_before);
        check("rst_after_valid", o_rsp_valid, 1'b0);
        check("rst_after_ready", o_cmd_ready, 1'b1);
        check("rst_after_cyc",   o_wb_cyc,    1'b0);
        @(posedge i_clk);
        #2;

        // 7: ack in the same cycle as issue, 4 beats, bits 1,0,0,1 -> 4'b1001
        start_test(0, -1, 0, 99);
        set_bits(8'b0000_1001, 4);
        send_cmd(1'b0, 1'b0, 8'h00, 3'd3, 8'h09, 1'b0);
        wait_done();
        check("ack0_stb_cnt", stb_cnt,  4);
        check("ack0_cyc_cnt", cyc_cnt,  4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
